// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the DMA bus arbiter: FSM state encoding
// and default register/target addresses.
package dma_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
    localparam logic [15:0] DEST_ADDR_DEF    = 16'h2004;

endpackage

// File: rtl/dma_bus_arbiter_bus_mux.sv
// 2:1 bus select between the CPU pins and the DMA engine.
// Ports: dma_owns_bus selects; cpu_* / dma_* sources; bus_* result.
module bus_mux
    import dma_pkg::*;
(
    input  logic        dma_owns_bus,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_odata,
    input  logic        cpu_rw,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_odata,
    input  logic        dma_rw,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_odata,
    output logic        bus_rw
);

    assign bus_addr  = dma_owns_bus ? dma_addr  : cpu_addr;
    assign bus_odata = dma_owns_bus ? dma_odata : cpu_odata;
    assign bus_rw    = dma_owns_bus ? dma_rw    : cpu_rw;

endmodule

// File: rtl/dma_bus_arbiter.sv
// Page-copy DMA arbiter sharing the 6502 memory bus.
// Ports: clk/reset; cyc bus-cycle strobe; cpu_* CPU pins; cpu_rdy stall;
// bus_* muxed memory bus; busy/dma_done status.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
    parameter logic [15:0] DEST_ADDR    = DEST_ADDR_DEF,
    parameter int          LEN          = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cyc,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_odata,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_odata,
    output logic        bus_rw,
    input  logic [7:0]  bus_idata,
    output logic        busy,
    output logic        dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    logic [2:0]  state;
    logic [7:0]  idx;
    logic [7:0]  page;
    logic [7:0]  data_buf;
    logic        parity;
    logic        dma_owns_bus;
    logic [15:0] dma_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= 8'h00;
            page     <= 8'h00;
            data_buf <= 8'h00;
            parity   <= 1'b0;
        end else if (cyc) begin
            parity <= ~parity;
            case (state)
                ST_IDLE: begin
                    if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
                        page  <= cpu_odata;
                        idx   <= 8'h00;
                        state <= ST_HALT;
                    end
                end
                // The 6502 ignores rdy on writes, so wait for a read.
                // parity=1 now means the next cycle is even.
                ST_HALT: begin
                    if (cpu_rw)
                        state <= parity ? ST_READ : ST_ALIGN;
                end
                ST_ALIGN: state <= ST_READ;
                ST_READ: begin
                    data_buf <= bus_idata;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= ST_READ;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dma_owns_bus = (state == ST_READ) || (state == ST_WRITE);
        busy         = (state == ST_HALT) || (state == ST_ALIGN) || dma_owns_bus;
        cpu_rdy      = ~busy;
        dma_done     = (state == ST_DONE);
        dma_addr     = (state == ST_READ) ? {page, idx} : DEST_ADDR;
    end

    bus_mux u_bus_mux (
        .dma_owns_bus (dma_owns_bus),
        .cpu_addr     (cpu_addr),
        .cpu_odata    (cpu_odata),
        .cpu_rw       (cpu_rw),
        .dma_addr     (dma_addr),
        .dma_odata    (data_buf),
        .dma_rw       (state == ST_READ),
        .bus_addr     (bus_addr),
        .bus_odata    (bus_odata),
        .bus_rw       (bus_rw)
    );

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter (LEN=256 main, LEN=4 second).
// Ports: none.
module tb_dma_bus_arbiter;

    localparam int L = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cyc = 1'b1;
    logic [15:0] cpu_addr = 16'h0200;
    logic [7:0]  cpu_odata = 8'h00;
    logic        cpu_rw = 1'b1;
    logic        cpu_rdy, busy, dma_done, bus_rw;
    logic [15:0] bus_addr;
    logic [7:0]  bus_odata, bus_idata;

    logic [15:0] c4_addr = 16'h0210;
    logic [7:0]  c4_odata = 8'h00;
    logic        c4_rw = 1'b1;
    logic        rdy4, busy4, done4, b4_rw;
    logic [15:0] b4_addr;
    logic [7:0]  b4_odata, b4_idata;

    logic [7:0] ram [0:65535];
    assign bus_idata = ram[bus_addr];
    assign b4_idata  = ram[b4_addr];

    dma_bus_arbiter dut (
        .clk(clk), .reset(reset), .cyc(cyc),
        .cpu_addr(cpu_addr), .cpu_odata(cpu_odata), .cpu_rw(cpu_rw),
        .cpu_rdy(cpu_rdy), .bus_addr(bus_addr), .bus_odata(bus_odata),
        .bus_rw(bus_rw), .bus_idata(bus_idata), .busy(busy),
        .dma_done(dma_done)
    );

    dma_bus_arbiter #(.LEN(4)) dut4 (
        .clk(clk), .reset(reset), .cyc(cyc),
        .cpu_addr(c4_addr), .cpu_odata(c4_odata), .cpu_rw(c4_rw),
        .cpu_rdy(rdy4), .bus_addr(b4_addr), .bus_odata(b4_odata),
        .bus_rw(b4_rw), .bus_idata(b4_idata), .busy(busy4),
        .dma_done(done4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: cycle index n counts cyc strobes since reset (parity = n%2).
    // mode 0 idle, 1 waiting for a CPU read, 2 transfer scheduled at s.
    int ncyc = 0;
    int mode = 0;
    int s = 0;
    logic [7:0] mpage = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ncyc = 0; mode = 0; s = 0; mpage = 8'h00;
        end else if (cyc) begin
            case (mode)
                0: if (!cpu_rw && cpu_addr == 16'h4014) begin
                    mpage = cpu_odata; mode = 1;
                end
                1: if (cpu_rw) begin
                    s = (ncyc % 2 == 1) ? ncyc + 1 : ncyc + 2;
                    mode = 2;
                end
                2: if (ncyc == s + 2 * L) mode = 0;
                default: mode = 0;
            endcase
            ncyc++;
        end
    end

    logic        e_rdy, e_busy, e_done, e_rw, chk_od;
    logic [15:0] e_addr;
    logic [7:0]  e_od;
    int          k;

    always @(negedge clk) begin
        e_rdy = 1; e_busy = 0; e_done = 0; chk_od = 1;
        e_addr = cpu_addr; e_od = cpu_odata; e_rw = cpu_rw; k = 0;
        if (mode == 1) begin
            e_rdy = 0; e_busy = 1;
        end else if (mode == 2) begin
            if (ncyc < s) begin
                e_rdy = 0; e_busy = 1;
            end else if (ncyc < s + 2 * L) begin
                k = ncyc - s;
                e_rdy = 0; e_busy = 1;
                if (k % 2 == 0) begin
                    e_addr = {mpage, 8'(k / 2)}; e_rw = 1; chk_od = 0;
                end else begin
                    e_addr = 16'h2004; e_rw = 0;
                    e_od = ram[{mpage, 8'((k - 1) / 2)}];
                end
            end else begin
                e_done = 1;
            end
        end
        total++;
        if (cpu_rdy !== e_rdy || busy !== e_busy || dma_done !== e_done ||
            bus_addr !== e_addr || bus_rw !== e_rw ||
            (chk_od && bus_odata !== e_od)) begin
            bad++;
            $display("FAIL cyc%0d rdy,busy,done,addr,od,rw got %b%b%b %h %h %b want %b%b%b %h %h %b",
                ncyc, cpu_rdy, busy, dma_done, bus_addr, bus_odata, bus_rw,
                e_rdy, e_busy, e_done, e_addr, e_od, e_rw);
        end
    end

    int stall_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int stall4 = 0, done4_cnt = 0;
    bit rd_seen = 0;
    logic [15:0] first_rd = 0, last_rd = 0, last_rd4 = 0;
    int first_par = 0;
    logic [7:0] q4 [$];

    always @(negedge clk) begin
        if (!busy) rd_seen = 0;
        if (!reset && cyc) begin
            if (!cpu_rdy) stall_cnt++;
            if (!bus_rw && bus_addr == 16'h2004) wr_cnt++;
            if (dma_done) done_cnt++;
            if (busy && bus_rw && bus_addr != cpu_addr) begin
                if (!rd_seen) begin
                    first_rd = bus_addr; first_par = ncyc % 2; rd_seen = 1;
                end
                last_rd = bus_addr;
            end
            if (!rdy4) stall4++;
            if (!b4_rw && b4_addr == 16'h2004) q4.push_back(b4_odata);
            if (busy4 && b4_rw && b4_addr != c4_addr) last_rd4 = b4_addr;
            if (done4) done4_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d,
                         input logic w);
        cpu_addr = a; cpu_odata = d; cpu_rw = w;
        @(posedge clk); #1;
    endtask

    task automatic trigger(input logic [7:0] pg, input int par);
        if (ncyc % 2 != par) drive(16'h0210, 8'h00, 1'b1);
        drive(16'h4014, pg, 1'b0);
    endtask

    task automatic run_to_done(input int inject, input bit gaps);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < 3000) begin
            cyc = (gaps && i % 37 == 5) ? 1'b0 : 1'b1;
            if (i == inject) drive(16'h4014, 8'h07, 1'b0);
            else drive(16'h0210, 8'h00, 1'b1);
            i++;
        end
        cyc = 1'b1;
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL done_timeout: got none want dma_done");
        end
    endtask

    initial begin
        int s0, w0, t0;
        bit found;
        for (int i = 0; i < 65536; i++)
            ram[i] = 8'((i * 13) ^ (i >> 8) ^ 90);
        ram[16'h1200] = 8'hAA; ram[16'h1201] = 8'h55;
        ram[16'h1202] = 8'h01; ram[16'h1203] = 8'hFE;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", cpu_rdy, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", dma_done, 0);
        chk("reset_pass", bus_addr, 16'h0200);
        reset = 1'b0;

        // LDA #$84; STA $99
        drive(16'h0200, 8'h00, 1'b1);
        drive(16'h0201, 8'h00, 1'b1);
        drive(16'h0202, 8'h00, 1'b1);
        drive(16'h0203, 8'h00, 1'b1);
        cpu_addr = 16'h0099; cpu_odata = 8'h84; cpu_rw = 1'b0;
        #2;
        chk("sta_addr", bus_addr, 16'h0099);
        chk("sta_data", bus_odata, 8'h84);
        chk("sta_rw", bus_rw, 0);
        chk("sta_rdy", cpu_rdy, 1);
        chk("sta_busy", busy, 0);
        @(posedge clk); #1;

        // Even-aligned trigger
        s0 = stall_cnt; w0 = wr_cnt;
        trigger(8'h03, 0);
        run_to_done(-1, 1'b0);
        chk("even_stall", stall_cnt - s0, 513);
        chk("even_writes", wr_cnt - w0, 256);
        chk("even_first", first_rd, 16'h0300);
        chk("even_last", last_rd, 16'h03FF);
        chk("even_rdy_after", cpu_rdy, 1);
        chk("even_busy_after", busy, 0);

        // Odd-aligned trigger
        s0 = stall_cnt; w0 = wr_cnt;
        trigger(8'h03, 1);
        run_to_done(-1, 1'b0);
        chk("odd_stall", stall_cnt - s0, 514);
        chk("odd_writes", wr_cnt - w0, 256);
        chk("odd_first", first_rd, 16'h0300);
        chk("odd_first_par", first_par, 0);

        // CPU finishes a write in HALT, then a re-trigger mid-transfer
        s0 = stall_cnt; w0 = wr_cnt;
        trigger(8'h03, 0);
        drive(16'h0050, 8'h11, 1'b0);
        run_to_done(100, 1'b0);
        chk("retrig_stall", stall_cnt - s0, 515);
        chk("retrig_writes", wr_cnt - w0, 256);
        chk("retrig_first", first_rd, 16'h0300);
        chk("retrig_last", last_rd, 16'h03FF);

        // Reset during the WRITE of idx $40
        trigger(8'h03, 0);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            drive(16'h0210, 8'h00, 1'b1);
            if (!bus_rw && bus_addr == 16'h2004 && last_rd == 16'h0340)
                found = 1;
        end
        chk("rst_reach_idx40", found, 1);
        reset = 1'b1;
        #1;
        chk("rst_rdy", cpu_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_addr", bus_addr, 16'h0210);
        chk("rst_rw", bus_rw, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        w0 = wr_cnt;
        repeat (10) drive(16'h0210, 8'h00, 1'b1);
        chk("rst_no_writes", wr_cnt - w0, 0);
        s0 = stall_cnt; w0 = wr_cnt;
        trigger(8'h03, 0);
        run_to_done(-1, 1'b1);
        chk("clean_stall", stall_cnt - s0, 513);
        chk("clean_writes", wr_cnt - w0, 256);

        // LEN=4 instance, page $12
        t0 = stall4;
        q4.delete();
        if (ncyc % 2 != 0) drive(16'h0210, 8'h00, 1'b1);
        c4_addr = 16'h4014; c4_odata = 8'h12; c4_rw = 1'b0;
        drive(16'h0210, 8'h00, 1'b1);
        c4_addr = 16'h0210; c4_rw = 1'b1;
        s0 = done4_cnt;
        for (int i = 0; i < 100 && done4_cnt == s0; i++)
            drive(16'h0210, 8'h00, 1'b1);
        chk("len4_done", done4_cnt - s0, 1);
        chk("len4_count", q4.size(), 4);
        if (q4.size() == 4) begin
            chk("len4_d0", q4[0], 8'hAA);
            chk("len4_d1", q4[1], 8'h55);
            chk("len4_d2", q4[2], 8'h01);
            chk("len4_d3", q4[3], 8'hFE);
        end
        chk("len4_last_rd", last_rd4, 16'h1203);
        chk("len4_stall", stall4 - t0, 9);
        chk("len4_busy", busy4, 0);
        chk("len4_rdy", rdy4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
